// File: rtl/control_cmd_stream.sv
// LED panel command decoder: byte stream -> colour/brightness enables and frame RAM line/fill writes.
// Optional idle-abort of open commands is enabled by defining CMD_TIMEOUT_EN.
module control_cmd_stream #(
  parameter int PIXEL_COLUMNS   = 64,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int ROWS            = 32,
  parameter int BRIGHTNESS_BITS = 6,
  parameter int TIMEOUT_TICKS   = 65535,
  localparam int LINE_BYTES = PIXEL_COLUMNS * BYTES_PER_PIXEL,
  localparam int ROW_W      = $clog2(ROWS),
  localparam int COL_W      = $clog2(LINE_BYTES),
  localparam int ADDR_W     = ROW_W + COL_W
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic [2:0]                 rgb_enable,
  output logic [BRIGHTNESS_BITS-1:0] brightness_enable,
  output logic [7:0]                 ram_data_out,
  output logic [ADDR_W-1:0]          ram_address,
  output logic                       ram_write_enable,
  output logic                       busy,
  output logic [7:0]                 num_commands_processed,
  output logic [7:0]                 num_errors
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LINE_ROW  = 3'd1;
  localparam logic [2:0] S_LINE_DATA = 3'd2;
  localparam logic [2:0] S_FILL_VAL  = 3'd3;
  localparam logic [2:0] S_FILL_RUN  = 3'd4;

  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(ROWS * LINE_BYTES - 1);

  if (BRIGHTNESS_BITS < 1 || BRIGHTNESS_BITS > 8 || TIMEOUT_TICKS < 1) begin : g_bad_params
    $error("control_cmd_stream: BRIGHTNESS_BITS must be 1..8 and TIMEOUT_TICKS >= 1");
  end

  logic [2:0]                 state;
  logic [ROW_W-1:0]           row;
  logic [COL_W-1:0]           col;
  logic [7:0]                 fill_value;
  logic [ADDR_W-1:0]          fill_addr;
  logic [BRIGHTNESS_BITS-1:0] plane_mask;

  // Digit '1' selects the most significant plane, '2' the next one down, and so on.
  always_comb begin
    plane_mask = '0;
    for (int unsigned i = 1; i <= BRIGHTNESS_BITS; i++) begin
      if (byte_in == 8'(8'h30 + i)) plane_mask[BRIGHTNESS_BITS-i] = 1'b1;
    end
  end

  assign busy = (state != S_IDLE);

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] idle_cnt;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state                  <= S_IDLE;
      rgb_enable             <= 3'b111;
      brightness_enable      <= '1;
      ram_data_out           <= '0;
      ram_address            <= '0;
      ram_write_enable       <= 1'b0;
      num_commands_processed <= '0;
      num_errors             <= '0;
      row                    <= '0;
      col                    <= '0;
      fill_value             <= '0;
      fill_addr              <= '0;
`ifdef CMD_TIMEOUT_EN
      idle_cnt               <= '0;
`endif
    end else begin
      ram_write_enable <= 1'b0;
      case (state)
        S_IDLE: if (byte_valid) begin
          case (byte_in)
            "R":     rgb_enable[0] <= 1'b1;
            "r":     rgb_enable[0] <= 1'b0;
            "G":     rgb_enable[1] <= 1'b1;
            "g":     rgb_enable[1] <= 1'b0;
            "B":     rgb_enable[2] <= 1'b1;
            "b":     rgb_enable[2] <= 1'b0;
            "0":     brightness_enable <= '0;
            "9":     brightness_enable <= '1;
            "L":     state <= S_LINE_ROW;
            "F":     state <= S_FILL_VAL;
            default: brightness_enable <= brightness_enable ^ plane_mask;
          endcase
        end
        S_LINE_ROW: if (byte_valid) begin
          if (int'(byte_in) >= ROWS) begin
            num_errors <= num_errors + 8'd1;
            state      <= S_IDLE;
          end else begin
            row   <= byte_in[ROW_W-1:0];
            col   <= '0;
            state <= S_LINE_DATA;
          end
        end
        S_LINE_DATA: if (byte_valid) begin
          ram_write_enable <= 1'b1;
          ram_data_out     <= byte_in;
          ram_address      <= {row, col};
          col              <= col + 1'b1;
          if (col == '1) begin
            num_commands_processed <= num_commands_processed + 8'd1;
            state                  <= S_IDLE;
          end
        end
        S_FILL_VAL: if (byte_valid) begin
          fill_value <= byte_in;
          fill_addr  <= '0;
          state      <= S_FILL_RUN;
        end
        S_FILL_RUN: begin
          ram_write_enable <= 1'b1;
          ram_data_out     <= fill_value;
          ram_address      <= fill_addr;
          fill_addr        <= fill_addr + 1'b1;
          if (byte_valid) num_errors <= num_errors + 8'd1;
          if (fill_addr == FILL_LAST) begin
            num_commands_processed <= num_commands_processed + 8'd1;
            state                  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef CMD_TIMEOUT_EN
      // Only an open command with no byte this cycle can expire, so no other branch above is active then.
      if (byte_valid || state == S_IDLE || state == S_FILL_RUN) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
        idle_cnt   <= '0;
        state      <= S_IDLE;
        num_errors <= num_errors + 8'd1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
`endif
    end
  end

endmodule
